// File: rtl/request_queue_pkg.sv
// Shared constants for the request queue: class encodings and default sizes.
package request_queue_pkg;

  // Class tag carried on out_class alongside each popped request word.
  localparam logic CLASS_PRIORITY = 1'b1;
  localparam logic CLASS_NORMAL   = 1'b0;

  // Default geometry used by the top level and the interface.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_AGE_LIMIT  = 4;

  // Which FIFO (if any) is popped in a given cycle.
  typedef enum logic [1:0] {
    POP_NONE = 2'b00,
    POP_NORM = 2'b01,
    POP_PRIO = 2'b10
  } pop_sel_e;

  // Width of a FIFO pointer: one extra bit distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/request_queue_if.sv
// Request/grant/output bundle between the request queue and its neighbours.
// The slave side is the queue itself; the master side is the upstream
// producers plus the arbiter grant lines.
interface request_queue_if
  import request_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  // Producer side
  logic                  prio_push;
  logic [DATA_WIDTH-1:0] prio_data;
  logic                  prio_full;
  logic                  norm_push;
  logic [DATA_WIDTH-1:0] norm_data;
  logic                  norm_full;

  // Arbiter side
  logic                  req_priority;
  logic                  req_normal;
  logic                  grant_priority;
  logic                  grant_normal;

  // Downstream side
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_class;
  logic                  drop;

  modport master (
    output prio_push, prio_data, norm_push, norm_data,
    output grant_priority, grant_normal,
    input  prio_full, norm_full, req_priority, req_normal,
    input  out_valid, out_data, out_class, drop
  );

  modport slave (
    input  prio_push, prio_data, norm_push, norm_data,
    input  grant_priority, grant_normal,
    output prio_full, norm_full, req_priority, req_normal,
    output out_valid, out_data, out_class, drop
  );

endinterface

// File: rtl/request_queue_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// A push while full and a pop while empty are both ignored here, so the
// caller may present raw requests; the head word is available combinationally.
module sync_fifo
  import request_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Pointers equal: empty. Pointers differ only in the wrap bit: full.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Full and empty are judged on the state before this edge, so a push to a
  // full FIFO is lost even if the same cycle pops it, and a pop of an empty
  // FIFO is ignored even if the same cycle pushes it.
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop  && !w_empty;

  // Write pointer advances on every accepted push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
    end else if (w_push_ok) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
    end else if (w_pop_ok) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/request_queue.sv
// Upstream request buffer for the I/O arbiter. Two independent FIFOs hold
// priority and normal requests; each legal grant pops one head word and
// presents it downstream for a single cycle. An aging counter withholds the
// priority request after AGE_LIMIT consecutive priority pops so that a
// waiting normal request is eventually granted.
module request_queue
  import request_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AGE_LIMIT  = DEF_AGE_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  request_queue_if.slave     bus
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [DATA_WIDTH-1:0] w_prio_head;
  logic [DATA_WIDTH-1:0] w_norm_head;
  logic                  w_prio_full;
  logic                  w_prio_empty;
  logic                  w_norm_full;
  logic                  w_norm_empty;
  logic                  w_age_block;
  logic                  w_prio_pop;
  logic                  w_norm_pop;
  logic                  w_drop;
  pop_sel_e              w_pop_sel;

  logic [AGE_W-1:0]      r_age;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_class;
  logic                  r_drop;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_prio_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.prio_push),
    .i_pop   (w_prio_pop),
    .i_data  (bus.prio_data),
    .o_data  (w_prio_head),
    .o_full  (w_prio_full),
    .o_empty (w_prio_empty)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_norm_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.norm_push),
    .i_pop   (w_norm_pop),
    .i_data  (bus.norm_data),
    .o_data  (w_norm_head),
    .o_full  (w_norm_full),
    .o_empty (w_norm_empty)
  );

  assign w_age_block = (r_age == AGE_W'(AGE_LIMIT));

  // Pop steering: priority wins when both grants are legal; a priority grant
  // that is blocked by aging or hits an empty FIFO lets a concurrent normal
  // grant through instead. At most one pop per cycle.
  always_comb begin
    w_pop_sel = POP_NONE;
    if (bus.grant_priority && !w_prio_empty && !w_age_block) begin
      w_pop_sel = POP_PRIO;
    end else if (bus.grant_normal && !w_norm_empty) begin
      w_pop_sel = POP_NORM;
    end
  end

  assign w_prio_pop = (w_pop_sel == POP_PRIO);
  assign w_norm_pop = (w_pop_sel == POP_NORM);

  // A push into a full FIFO is discarded; full is taken before any pop.
  assign w_drop = (bus.prio_push && w_prio_full) || (bus.norm_push && w_norm_full);

  // Aging: count priority pops while normal work waits, saturate at the
  // limit, and restart whenever normal work is served or none is waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_age <= '0;
    end else if (w_norm_pop || w_norm_empty) begin
      r_age <= '0;
    end else if (w_prio_pop && !w_age_block) begin
      r_age <= r_age + 1'b1;
    end
  end

  // Output strobe: one cycle per pop, carrying the popped word and its class.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_class <= CLASS_NORMAL;
    end else begin
      r_out_valid <= w_prio_pop || w_norm_pop;
      if (w_prio_pop) begin
        r_out_data  <= w_prio_head;
        r_out_class <= CLASS_PRIORITY;
      end else if (w_norm_pop) begin
        r_out_data  <= w_norm_head;
        r_out_class <= CLASS_NORMAL;
      end
    end
  end

  // Drop strobe: registered so it lines up with the push edge it reports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
    end
  end

  // Request lines and full flags come straight from registered FIFO state,
  // so a push or pop at one edge is reflected right after that edge.
  assign bus.req_normal   = !w_norm_empty;
  assign bus.req_priority = !w_prio_empty && !w_age_block;
  assign bus.prio_full    = w_prio_full;
  assign bus.norm_full    = w_norm_full;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_class    = r_out_class;
  assign bus.drop         = r_drop;

endmodule
